// File: rtl/store_unit.sv
// store_unit: turns one execute-stage store (address, right-aligned data,
// size) into a single word-aligned data-memory write with lane-shifted data
// and byte mask. Owns the memory valid/ready handshake, a response timeout,
// and reports done / misaligned / fault back to the core.
module store_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TO_WIDTH    = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  write_strobe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        st_done,
  output logic        st_misaligned,
  output logic        st_fault
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;
  localparam logic [1:0] ERR   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [TO_WIDTH-1:0] cnt_q;
  logic [TO_WIDTH-1:0] cnt_d;
  logic                timeout_c;
  logic                limit_hit_c;
  logic                illegal_c;
  logic                accept_c;
  logic [1:0]          off_c;
  logic [31:0]         lane_data_c;
  logic [3:0]          lane_mask_c;

  // Request is only taken while idle; st_ready is a pure decode of the state.
  assign st_ready = (state_q == IDLE);
  assign accept_c = (state_q == IDLE) && st_valid;

  // Count reaching the limit on this cycle (timeout disabled when limit is 0).
  assign limit_hit_c = (MEM_TIMEOUT != 0) &&
                       (cnt_q == TO_WIDTH'(MEM_TIMEOUT - 1));

  // Alignment check and lane placement of the incoming request.
  always_comb begin
    off_c       = st_addr[1:0];
    lane_data_c = 32'd0;
    lane_mask_c = 4'd0;
    illegal_c   = 1'b0;
    case (write_strobe)
      SZ_BYTE: begin
        lane_data_c = {24'd0, st_data[7:0]} << {off_c, 3'b000};
        lane_mask_c = 4'b0001 << off_c;
      end
      SZ_HALF: begin
        // Offsets 1 and 2 still fit inside one word.
        illegal_c   = (off_c == 2'd3);
        lane_data_c = {16'd0, st_data[15:0]} << {off_c, 3'b000};
        lane_mask_c = 4'b0011 << off_c;
      end
      SZ_WORD: begin
        illegal_c   = (off_c != 2'd0);
        lane_data_c = st_data;
        lane_mask_c = 4'b1111;
      end
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

  // Next-state and timeout counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (st_valid) begin
          state_d = illegal_c ? ERR : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          // A handshake on the limit cycle still counts as success.
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
          if (limit_hit_c) begin
            state_d   = RESP;
            timeout_c = 1'b1;
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      mem_valid     <= 1'b0;
      st_done       <= 1'b0;
      st_misaligned <= 1'b0;
      st_fault      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mem_valid     <= (state_d == ISSUE);
      st_done       <= (state_d == RESP) || (state_d == ERR);
      st_misaligned <= (state_d == ERR);
      st_fault      <= timeout_c;
    end
  end

  // Write payload captured on a legal accept and held through the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_wmask <= 4'd0;
    end else if (accept_c && !illegal_c) begin
      mem_addr  <= {st_addr[31:2], 2'b00};
      mem_wdata <= lane_data_c;
      mem_wmask <= lane_mask_c;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: stimulus pushes expected writes and
// completions; a negedge monitor compares whatever the DUT presents.
module tb_store_unit;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  write_strobe;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        st_done;
  logic        st_misaligned;
  logic        st_fault;

  store_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .st_valid     (st_valid),
    .st_ready     (st_ready),
    .st_addr      (st_addr),
    .st_data      (st_data),
    .write_strobe (write_strobe),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .st_done      (st_done),
    .st_misaligned(st_misaligned),
    .st_fault     (st_fault)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } wr_t;

  typedef struct {
    bit mis;
    bit fault;
    int lat;
  } done_t;

  wr_t   wr_q[$];
  done_t done_q[$];
  int    acc_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ready_delay = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory responder: raise mem_ready after ready_delay cycles of mem_valid (-1 = never).
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!mem_valid) begin
        wcnt = 0;
        mem_ready = 1'b0;
      end else begin
        mem_ready = (ready_delay >= 0) && (wcnt >= ready_delay);
        wcnt = wcnt + 1;
      end
    end
  end

  // Monitor: compares presented writes and completions against the queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (st_valid && st_ready) acc_q.push_back(cyc + 1);
      if (mem_valid) begin
        if (wr_q.size() == 0) begin
          check("spurious_mem_valid", 32'(mem_valid), 32'd0);
        end else begin
          check("mem_addr", mem_addr, wr_q[0].addr);
          check("mem_wdata", mem_wdata, wr_q[0].wdata);
          check("mem_wmask", 32'(mem_wmask), 32'(wr_q[0].mask));
          if (mem_ready) void'(wr_q.pop_front());
        end
      end
      if (st_done) begin
        if (done_q.size() == 0) begin
          check("spurious_st_done", 32'(st_done), 32'd0);
        end else begin
          done_t d;
          d = done_q.pop_front();
          check("st_misaligned", 32'(st_misaligned), 32'(d.mis));
          check("st_fault", 32'(st_fault), 32'(d.fault));
          if (acc_q.size() == 0) check("accept_seen", 32'd0, 32'd1);
          else check("done_latency", 32'(cyc + 1 - acc_q.pop_front()), 32'(d.lat));
          if (d.fault && wr_q.size() != 0) void'(wr_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                      input int dly, input bit mis, input bit fault, input int lat,
                      input logic [31:0] ewd, input logic [3:0] emask, input bit hold);
    int n;
    ready_delay = dly;
    done_q.push_back('{mis: mis, fault: fault, lat: lat});
    if (!mis) wr_q.push_back('{addr: {a[31:2], 2'b00}, wdata: ewd, mask: emask});
    st_addr = a;
    st_data = d;
    write_strobe = s;
    st_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (st_ready) break;
      n = n + 1;
      if (n > 100) begin
        check("accept_timeout", 32'(st_ready), 32'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!hold) st_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (done_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n = n + 1;
    end
    check("drain_done", 32'(done_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3;
    rst_n = 1'b0;
    st_valid = 1'b0;
    st_addr = 32'd0;
    st_data = 32'd0;
    write_strobe = 2'b00;

    // Reset state.
    #3;
    check("rst_st_ready", 32'(st_ready), 32'd1);
    check("rst_mem_valid", 32'(mem_valid), 32'd0);
    check("rst_st_done", 32'(st_done), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Byte at offset 3, zero-wait memory.
    send(32'h0000_1003, 32'hABCD_12EF, 2'b00, 0, 1'b0, 1'b0, 2, 32'hEF00_0000, 4'b1000, 1'b0);
    wait_idle();
    // Halfword at offset 1 (legal), then offset 3 (misaligned).
    send(32'h0000_2001, 32'h0000_BEEF, 2'b01, 0, 1'b0, 1'b0, 2, 32'h00BE_EF00, 4'b0110, 1'b0);
    wait_idle();
    send(32'h0000_2003, 32'h0000_BEEF, 2'b01, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 1'b0);
    wait_idle();
    // Word with three wait cycles.
    send(32'h0000_3000, 32'hDEAD_BEEF, 2'b10, 3, 1'b0, 1'b0, 5, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    wait_idle();
    // Misaligned word and invalid size.
    send(32'h0000_3002, 32'hDEAD_BEEF, 2'b10, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 1'b0);
    wait_idle();
    send(32'h0000_3000, 32'hDEAD_BEEF, 2'b11, 0, 1'b1, 1'b0, 1, 32'd0, 4'd0, 1'b0);
    wait_idle();
    // Timeout: memory never answers.
    send(32'h0000_4000, 32'h1122_3344, 2'b10, -1, 1'b0, 1'b1, 17, 32'h1122_3344, 4'b1111, 1'b0);
    wait_idle();
    // Handshake on the limit cycle wins over the timeout.
    send(32'h0000_4002, 32'h0000_00A5, 2'b00, 15, 1'b0, 1'b0, 17, 32'h00A5_0000, 4'b0100, 1'b0);
    wait_idle();

    // Back-to-back with st_valid held high.
    send(32'h0000_5000, 32'h0000_0077, 2'b00, 0, 1'b0, 1'b0, 2, 32'h0000_0077, 4'b0001, 1'b1);
    c1 = cyc;
    send(32'h0000_5002, 32'h0000_1234, 2'b01, 0, 1'b0, 1'b0, 2, 32'h1234_0000, 4'b1100, 1'b1);
    c2 = cyc;
    send(32'h0000_5004, 32'hCAFE_F00D, 2'b10, 0, 1'b0, 1'b0, 2, 32'hCAFE_F00D, 4'b1111, 1'b0);
    c3 = cyc;
    check("b2b_gap1", 32'(c2 - c1), 32'd3);
    check("b2b_gap2", 32'(c3 - c2), 32'd3);
    wait_idle();

    // Reset while the write is pending in ISSUE.
    send(32'h0000_7000, 32'h0000_0099, 2'b10, -1, 1'b0, 1'b0, 2, 32'h0000_0099, 4'b1111, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_mem_valid", 32'(mem_valid), 32'd1);
    rst_n = 1'b0;
    done_q.delete();
    wr_q.delete();
    acc_q.delete();
    #1;
    check("mid_rst_mem_valid", 32'(mem_valid), 32'd0);
    check("mid_rst_st_ready", 32'(st_ready), 32'd1);
    repeat (2) begin
      @(negedge clk);
      check("mid_rst_st_done", 32'(st_done), 32'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_st_ready", 32'(st_ready), 32'd1);
    send(32'h0000_6001, 32'h0000_005A, 2'b00, 0, 1'b0, 1'b0, 2, 32'h0000_5A00, 4'b0010, 1'b0);
    wait_idle();

    check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
